// File: rtl/cmd_frame_tx.sv
// Command framing engine: sends opcode plus a 16-bit operand as three UART
// bytes, then waits for a one-byte response and resends the frame on timeout.
module cmd_frame_tx #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [7:0]  POS_ACK     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        clr_resp_rdy,
  output logic        busy,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        ack_ok,
  output logic        timeout_err,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_CMD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, WAIT_RESP
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_sh_cmd;
  logic [15:0]   r_sh_data;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_tx_data, r_resp;
  logic          r_cmd_sent, r_clr_rx, r_resp_rdy, r_ack_ok, r_timeout_err;

  logic          w_rx_new, w_tmo;
  logic          w_accept, w_take, w_retry, w_giveup, w_lo_done;
  logic          w_busy, w_trmt, w_load_tx;
  logic [7:0]    w_tx_byte;

  // rx_rdy is still high in the cycle the consume pulse is out; don't count it twice
  assign w_rx_new = rx_rdy & ~r_clr_rx;
  assign w_tmo    = (r_timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_take    = 1'b0;
    w_retry   = 1'b0;
    w_giveup  = 1'b0;
    w_lo_done = 1'b0;
    w_busy    = 1'b1;
    w_trmt    = 1'b0;
    w_load_tx = 1'b0;
    w_tx_byte = '0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (snd_cmd) begin
          w_accept  = 1'b1;
          w_load_tx = 1'b1;
          w_tx_byte = cmd;
          w_next    = SEND_CMD;
        end
      end
      SEND_CMD: begin
        w_trmt = 1'b1;
        w_next = WAIT_CMD;
      end
      WAIT_CMD: begin
        if (tx_done) begin
          w_load_tx = 1'b1;
          w_tx_byte = r_sh_data[15:8];
          w_next    = SEND_HI;
        end
      end
      SEND_HI: begin
        w_trmt = 1'b1;
        w_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_done) begin
          w_load_tx = 1'b1;
          w_tx_byte = r_sh_data[7:0];
          w_next    = SEND_LO;
        end
      end
      SEND_LO: begin
        w_trmt = 1'b1;
        w_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (tx_done) begin
          w_lo_done = 1'b1;
          w_next    = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // a response arriving on the timeout cycle still wins
        if (w_rx_new) begin
          w_take = 1'b1;
          w_next = IDLE;
        end else if (w_tmo) begin
          if (r_retry < RW'(MAX_RETRY)) begin
            w_retry   = 1'b1;
            w_load_tx = 1'b1;
            w_tx_byte = r_sh_cmd;
            w_next    = SEND_CMD;
          end else begin
            w_giveup = 1'b1;
            w_next   = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_cmd      <= '0;
      r_sh_data     <= '0;
      r_timer       <= '0;
      r_retry       <= '0;
      r_tx_data     <= '0;
      r_resp        <= '0;
      r_cmd_sent    <= 1'b0;
      r_clr_rx      <= 1'b0;
      r_resp_rdy    <= 1'b0;
      r_ack_ok      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cmd_sent <= w_lo_done;
      r_clr_rx   <= w_rx_new;
      if (w_accept) begin
        r_sh_cmd      <= cmd;
        r_sh_data     <= data;
        r_retry       <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_retry)   r_retry <= r_retry + RW'(1);
      if (w_giveup)  r_timeout_err <= 1'b1;
      if (w_load_tx) r_tx_data <= w_tx_byte;
      if (w_lo_done)
        r_timer <= '0;
      else if (r_state == WAIT_RESP && r_timer != '1)
        r_timer <= r_timer + TW'(1);
      if (w_take) begin
        r_resp     <= rx_data;
        r_ack_ok   <= (rx_data == POS_ACK);
        r_resp_rdy <= 1'b1;
      end else if (w_accept || clr_resp_rdy) begin
        r_resp_rdy <= 1'b0;
      end
    end
  end

  assign busy        = w_busy;
  assign trmt        = w_trmt;
  assign tx_data     = r_tx_data;
  assign cmd_sent    = r_cmd_sent;
  assign clr_rx_rdy  = r_clr_rx;
  assign resp        = r_resp;
  assign resp_rdy    = r_resp_rdy;
  assign ack_ok      = r_ack_ok;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Bench for cmd_frame_tx: host and UART loopback driven from one thread,
// with a per-cycle scoreboard of the transmitted byte stream and host status.
module tb_cmd_frame_tx;

  localparam int unsigned TMO  = 64;
  localparam int unsigned MAXR = 2;
  localparam logic [7:0]  ACK  = 8'hA5;

  logic        clk, rst_n, snd_cmd, clr_resp_rdy, tx_done, rx_rdy;
  logic [7:0]  cmd, rx_data;
  logic [15:0] data;
  logic        busy, cmd_sent, resp_rdy, ack_ok, timeout_err, trmt, clr_rx_rdy;
  logic [7:0]  resp, tx_data;

  cmd_frame_tx #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .POS_ACK(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .clr_resp_rdy(clr_resp_rdy), .busy(busy), .cmd_sent(cmd_sent),
    .resp(resp), .resp_rdy(resp_rdy), .ack_ok(ack_ok),
    .timeout_err(timeout_err), .tx_data(tx_data), .trmt(trmt),
    .tx_done(tx_done), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;

  // expected byte stream and host-visible status
  logic [7:0]  exp_q[$];
  int unsigned rd_idx = 0;
  logic [7:0]  m_resp = '0;
  logic        m_rdy = 1'b0, m_ack = 1'b0, m_terr = 1'b0;

  int   cyc = 0, n_trmt = 0, n_sent = 0, att_bytes = 0, sent_cyc = 0, lb_cnt = 0;
  bit   awaiting = 0, holding = 0, prev_trmt = 0;
  logic [7:0] held = '0;
  int   base_t, base_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // one cycle: sample at the falling edge, score, then drive the tx loopback
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      rd_idx = exp_q.size();
      awaiting = 0; holding = 0; att_bytes = 0; lb_cnt = 0; prev_trmt = 0;
    end else begin
      if (trmt) begin
        n_trmt++;
        att_bytes++;
        chk("trmt_single", prev_trmt, 0);
        if (rd_idx < exp_q.size()) begin
          chk("tx_byte", tx_data, exp_q[rd_idx]);
          rd_idx++;
        end else fail("tx_unexpected");
        if (awaiting) chk("retry_gap", cyc - sent_cyc, TMO);
        awaiting = 0;
        holding  = 1;
        held     = tx_data;
      end else if (holding) begin
        chk("tx_hold", tx_data, held);
      end
      if (tx_done && !trmt) holding = 0;
      if (cmd_sent) begin
        n_sent++;
        chk("bytes_per_frame", att_bytes, 3);
        att_bytes = 0;
        sent_cyc  = cyc;
        awaiting  = 1;
      end
      if (!busy) begin
        awaiting = 0; att_bytes = 0; holding = 0;
        chk("idle_resp", resp, m_resp);
        chk("idle_resp_rdy", resp_rdy, m_rdy);
        chk("idle_ack_ok", ack_ok, m_ack);
        chk("idle_timeout_err", timeout_err, m_terr);
      end
      prev_trmt = trmt;
    end
    tx_done = rst_n && (lb_cnt == 1);
    if (lb_cnt > 0) lb_cnt--;
    if (rst_n && trmt) lb_cnt = 10;
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
  endtask

  task automatic host_send(input logic [7:0] c, input logic [15:0] d);
    cmd = c; data = d; snd_cmd = 1'b1;
    m_rdy = 1'b0; m_terr = 1'b0;
    tick();
    snd_cmd = 1'b0; cmd = 8'hC3; data = 16'h3C3C;
  endtask

  task automatic wait_sent(input int target, input int lim);
    int k = 0;
    while (n_sent < target && k < lim) begin tick(); k++; end
    if (n_sent < target) fail("wait_cmd_sent");
  endtask

  task automatic wait_trmt(input int target, input int lim);
    int k = 0;
    while (n_trmt < target && k < lim) begin tick(); k++; end
    if (n_trmt < target) fail("wait_trmt");
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin tick(); k++; end
    if (busy) fail("wait_idle");
  endtask

  task automatic rx_send(input logic [7:0] b, input bit take);
    rx_data = b; rx_rdy = 1'b1;
    if (take) begin
      m_resp = b; m_ack = (b == ACK); m_rdy = 1'b1;
    end
    tick();
    chk("clr_rx_pulse", clr_rx_rdy, 1);
    rx_rdy = 1'b0;
    tick();
    chk("clr_rx_single", clr_rx_rdy, 0);
  endtask

  initial begin
    rst_n = 1'b0; snd_cmd = 1'b0; cmd = '0; data = '0; clr_resp_rdy = 1'b0;
    tx_done = 1'b0; rx_rdy = 1'b0; rx_data = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // positive acknowledge
    base_t = n_trmt; base_s = n_sent;
    push_frame(8'h02, 8'h12, 8'h34);
    host_send(8'h02, 16'h1234);
    wait_sent(base_s + 1, 200);
    repeat (3) tick();
    rx_send(8'hA5, 1);
    chk("t1_resp", resp, 8'hA5);
    chk("t1_ack_ok", ack_ok, 1);
    chk("t1_resp_rdy", resp_rdy, 1);
    chk("t1_busy", busy, 0);
    chk("t1_bytes", n_trmt - base_t, 3);
    chk("t1_cmd_sent", n_sent - base_s, 1);

    // negative response, then host clears resp_rdy
    base_s = n_sent;
    push_frame(8'h10, 8'hAB, 8'hCD);
    host_send(8'h10, 16'hABCD);
    wait_sent(base_s + 1, 200);
    repeat (2) tick();
    rx_send(8'hFF, 1);
    chk("t2_resp_rdy", resp_rdy, 1);
    chk("t2_ack_ok", ack_ok, 0);
    clr_resp_rdy = 1'b1; m_rdy = 1'b0;
    tick();
    clr_resp_rdy = 1'b0;
    chk("t2_resp_rdy_clr", resp_rdy, 0);
    chk("t2_resp_kept", resp, 8'hFF);

    // no response: first attempt plus two resends, then give up
    base_t = n_trmt; base_s = n_sent;
    repeat (3) push_frame(8'h3E, 8'h01, 8'h02);
    host_send(8'h3E, 16'h0102);
    wait_sent(base_s + 3, 700);
    m_terr = 1'b1;
    wait_idle(200);
    chk("t3_timeout_err", timeout_err, 1);
    chk("t3_resp_rdy", resp_rdy, 0);
    chk("t3_resp_kept", resp, 8'hFF);
    chk("t3_bytes", n_trmt - base_t, 9);

    // timeout once, answered on the resend
    base_t = n_trmt; base_s = n_sent;
    repeat (2) push_frame(8'h44, 8'hBE, 8'hEF);
    host_send(8'h44, 16'hBEEF);
    wait_sent(base_s + 2, 500);
    repeat (2) tick();
    rx_send(8'hA5, 1);
    chk("t4_resp", resp, 8'hA5);
    chk("t4_timeout_err", timeout_err, 0);
    chk("t4_bytes", n_trmt - base_t, 6);

    // snd_cmd while busy and a stray byte during the frame
    base_t = n_trmt; base_s = n_sent;
    push_frame(8'h60, 8'h78, 8'h9A);
    host_send(8'h60, 16'h789A);
    cmd = 8'h05; data = 16'hFFFF; snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    wait_trmt(base_t + 2, 100);
    tick();
    rx_send(8'h77, 0);
    chk("t5_stray_resp", resp, 8'hA5);
    wait_sent(base_s + 1, 200);
    tick();
    rx_send(8'h3C, 1);
    chk("t5_resp", resp, 8'h3C);
    chk("t5_ack_ok", ack_ok, 0);
    chk("t5_bytes", n_trmt - base_t, 3);

    // reset in the middle of a frame
    base_t = n_trmt;
    push_frame(8'h71, 8'h22, 8'h33);
    host_send(8'h71, 16'h2233);
    wait_trmt(base_t + 2, 100);
    tick();
    rst_n = 1'b0;
    m_resp = '0; m_rdy = 1'b0; m_ack = 1'b0; m_terr = 1'b0;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_cmd_sent", cmd_sent, 0);
    chk("t6_trmt", trmt, 0);
    chk("t6_clr_rx_rdy", clr_rx_rdy, 0);
    chk("t6_resp", resp, 8'h00);
    chk("t6_resp_rdy", resp_rdy, 0);
    chk("t6_ack_ok", ack_ok, 0);
    chk("t6_timeout_err", timeout_err, 0);
    chk("t6_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    repeat (15) tick();
    base_t = n_trmt; base_s = n_sent;
    push_frame(8'h21, 8'h5A, 8'h6B);
    host_send(8'h21, 16'h5A6B);
    wait_sent(base_s + 1, 200);
    tick();
    rx_send(8'hA5, 1);
    chk("t6_new_resp", resp, 8'hA5);
    chk("t6_new_bytes", n_trmt - base_t, 3);
    chk("stream_consumed", rd_idx, exp_q.size());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_frame_tx.md
# cmd_frame_tx

Initiator-side command framing engine for the remote command link. It accepts a command opcode and a 16-bit operand from the host and serializes them as three UART bytes: opcode, data[15:8], data[7:0]. It then waits for the single-byte response from the airframe's command receiver, retrying the whole frame on response timeout. It sits between host/remote control logic and a byte-level UART transceiver, and is the transmitting counterpart of the on-board command receiver and configuration block.

## Interface

Parameters:
- TIMEOUT_CYC, 2_000_000: clocks allowed in WAIT_RESP before the frame is retried.
- MAX_RETRY, 2: number of resends after the first attempt before giving up.
- POS_ACK, 8'hA5: response byte that counts as a positive acknowledge.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- snd_cmd  in  1  request to send a frame; sampled only in IDLE.
- cmd  in  8  opcode; latched on accept.
- data  in  16  operand; latched on accept.
- clr_resp_rdy  in  1  host clears resp_rdy.
- busy  out  1  high in every state except IDLE.
- cmd_sent  out  1  one-cycle pulse when the third byte of an attempt completes.
- resp  out  8  last received response byte.
- resp_rdy  out  1  level; a new response is valid.
- ack_ok  out  1  registered (resp == POS_ACK), updated with resp.
- timeout_err  out  1  level; all attempts timed out.
- tx_data  out  8  byte to the UART transmitter; held stable from the trmt pulse until tx_done.
- trmt  out  1  one-cycle transmit strobe.
- tx_done  in  1  UART transmitter finished the current byte.
- rx_rdy  in  1  UART receiver holds a byte.
- rx_data  in  8  received byte.
- clr_rx_rdy  out  1  one-cycle pulse that consumes rx_data.

## Operation

- States: IDLE, SEND_CMD, WAIT_CMD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, WAIT_RESP.
- IDLE + snd_cmd:
  - Latch cmd and data into shadow registers, clear retry count, resp_rdy, and timeout_err.
  - Go to SEND_CMD.
  - snd_cmd in any other state is ignored. Its inputs are not latched.
- Each SEND_x state lasts one cycle. It asserts trmt, drives tx_data, and goes to WAIT_x.
- Byte order: SEND_CMD drives the shadow cmd, SEND_HI drives shadow data[15:8], SEND_LO drives shadow data[7:0].
- WAIT_x advances on tx_done: WAIT_CMD to SEND_HI, WAIT_HI to SEND_LO, WAIT_LO to WAIT_RESP. The WAIT_LO exit pulses cmd_sent and clears the timer.
- WAIT_RESP + rx_rdy: resp <= rx_data, ack_ok updated, resp_rdy set, clr_rx_rdy pulsed, go to IDLE.
- Timeout: timer reaches TIMEOUT_CYC-1 in WAIT_RESP with no rx_rdy.
  - If retry count < MAX_RETRY: increment it and go to SEND_CMD, resending the shadow values unchanged.
  - Otherwise: set timeout_err, leave resp and resp_rdy unchanged, go to IDLE.
- rx_rdy outside WAIT_RESP is a stray byte: pulse clr_rx_rdy and discard it. resp is untouched.
- resp_rdy clears on clr_resp_rdy or on a new accept. Setting it has priority over clr_resp_rdy in the same cycle.
- Timer is 21 bits wide (sized by $clog2(TIMEOUT_CYC)), counts only in WAIT_RESP, and saturates. Retry counter is sized by $clog2(MAX_RETRY+1).

## Timing

- Reset values: IDLE; busy, cmd_sent, trmt, clr_rx_rdy, resp_rdy, ack_ok, timeout_err = 0; resp, tx_data, and shadow registers = 0; timer and retry count = 0.
- Reset mid-frame aborts immediately. The frame is not resumed.
- Accept at edge N: busy = 1 and trmt = 1 with tx_data = cmd during cycle N+1.
- tx_done at edge M in WAIT_x: the next trmt is high during cycle M+1. tx_done in WAIT_LO gives cmd_sent high during cycle M+1.
- rx_rdy at edge R in WAIT_RESP: resp, ack_ok, and resp_rdy are valid from cycle R+1, clr_rx_rdy is high during R+1, and busy = 0 from R+1.
- rx_rdy and timeout in the same cycle: the response wins and there is no retry.
- With no response, the retry trmt comes exactly TIMEOUT_CYC cycles after the cmd_sent cycle.
- tx_done in a SEND state, or in IDLE, is ignored.

## Test plan

- TIMEOUT_CYC = 64. Send cmd = 8'h02, data = 16'h1234; loop tx_done back 10 cycles after each trmt; return 8'hA5 -> tx_data sequence 02, 12, 34; one cmd_sent pulse; resp = A5, ack_ok = 1, resp_rdy = 1, busy = 0.
- Respond with 8'hFF -> resp_rdy = 1, ack_ok = 0. Then assert clr_resp_rdy -> resp_rdy = 0 next cycle, resp still FF.
- No response, MAX_RETRY = 2 -> three complete 3-byte frames with identical bytes, each starting 64 cycles after the previous cmd_sent; then timeout_err = 1, resp_rdy = 0, IDLE.
- Timeout on the first attempt, then respond A5 on the retry -> exactly two frames, resp = A5, timeout_err = 0.
- snd_cmd with cmd = 8'h05 while busy; stray rx_rdy during WAIT_HI -> the frame still carries the original bytes; the stray byte gets clr_rx_rdy and resp is unchanged.
- rst_n low during WAIT_HI -> the next cycle shows every output at its reset value. A new snd_cmd afterwards sends a full, clean 3-byte frame.
